// File: rtl/hazard_pkg.sv
// Shared types and helpers for the forwarding/hazard unit.
package hazard_pkg;

  localparam int FWD_SEL_W = 2;

  typedef logic [FWD_SEL_W-1:0] fwd_sel_t;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } hz_state_e;

  // Select code meaning "take the operand from the register file".
  localparam fwd_sel_t FWD_REGFILE = '0;

  // Producer stage k is encoded as k+1 so that 0 stays free for the regfile.
  function automatic int fwd_code(input int k);
    return k + 1;
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Pending-register scoreboard and outstanding-op counter for the multi-cycle unit.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int MC_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               issue,
  input  logic [REG_AW-1:0]                  issue_addr,
  input  logic                               retire,
  input  logic [REG_AW-1:0]                  retire_addr,
  output logic [(2**REG_AW)-1:0]             pending,
  output logic [$clog2(MC_DEPTH+1)-1:0]      count,
  output logic                               full
);

  localparam int CNT_AW = $clog2(MC_DEPTH + 1);
  localparam logic [CNT_AW-1:0] DEPTH_VAL = CNT_AW'(MC_DEPTH);

  // Retire clears first so that a same-cycle issue to the same register re-sets it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
    end else begin
      if (retire) begin
        pending[retire_addr] <= 1'b0;
      end
      if (issue && issue_addr != '0) begin
        pending[issue_addr] <= 1'b1;
      end
    end
  end

  // Outstanding-op count; issue and retire together cancel out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else begin
      case ({issue, retire})
        2'b10: if (count != DEPTH_VAL) count <= count + CNT_AW'(1);
        2'b01: if (count != '0)        count <= count - CNT_AW'(1);
        default: ;
      endcase
    end
  end

  assign full = (count == DEPTH_VAL);

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding, load-use and multi-cycle hazard detection, fence drain and stall counting.
module fwd_hazard_unit
  import hazard_pkg::*;
#(
  parameter int NUM_RS   = 2,
  parameter int NUM_FWD  = 2,
  parameter int REG_AW   = 5,
  parameter int MC_DEPTH = 4,
  parameter int CNT_W    = 32,
  localparam int SELW    = $clog2(NUM_FWD + 1)
) (
  input  logic                             i_clk,
  input  logic                             i_reset,
  input  logic [NUM_RS-1:0][REG_AW-1:0]    i_rs_addr_D,
  input  logic [NUM_RS-1:0]                i_rs_used_D,
  input  logic [REG_AW-1:0]                i_rd_addr_D,
  input  logic                             i_mc_req_D,
  input  logic                             i_fence_D,
  input  logic [REG_AW-1:0]                i_rd_addr_E,
  input  logic                             i_is_load_E,
  input  logic [NUM_FWD-1:0]               i_fwd_wren,
  input  logic [NUM_FWD-1:0][REG_AW-1:0]   i_fwd_addr,
  input  logic                             i_mc_issue,
  input  logic                             i_mc_wb_valid,
  input  logic [REG_AW-1:0]                i_mc_wb_addr,
  input  logic                             i_cnt_clr,
  output logic [NUM_RS-1:0][SELW-1:0]      o_fwd_sel,
  output logic                             o_stall_D,
  output logic                             o_flush_E,
  output logic                             o_mc_busy,
  output logic                             o_fence_done,
  output logic [CNT_W-1:0]                 o_stall_cycles
);

  localparam int NUM_REGS = 2**REG_AW;
  localparam int MC_CNT_W = $clog2(MC_DEPTH + 1);

  logic [NUM_REGS-1:0] pending;
  logic [MC_CNT_W-1:0] mc_count;
  logic                mc_full;
  logic                load_use;
  logic                mc_hazard;
  hz_state_e           state;

  hazard_scoreboard #(
    .REG_AW   (REG_AW),
    .MC_DEPTH (MC_DEPTH)
  ) u_scoreboard (
    .clk         (i_clk),
    .rst         (i_reset),
    .issue       (i_mc_issue),
    .issue_addr  (i_rd_addr_D),
    .retire      (i_mc_wb_valid),
    .retire_addr (i_mc_wb_addr),
    .pending     (pending),
    .count       (mc_count),
    .full        (mc_full)
  );

  // Walk stages oldest to youngest so the youngest matching producer overrides.
  always_comb begin
    o_fwd_sel = '0;
    for (int p = 0; p < NUM_RS; p++) begin
      o_fwd_sel[p] = SELW'(FWD_REGFILE);
      for (int k = NUM_FWD - 1; k >= 0; k--) begin
        if (i_fwd_wren[k] && i_fwd_addr[k] != '0 && i_fwd_addr[k] == i_rs_addr_D[p]) begin
          o_fwd_sel[p] = SELW'(fwd_code(k));
        end
      end
      if (i_reset) begin
        o_fwd_sel[p] = SELW'(FWD_REGFILE);
      end
    end
  end

  // Hazard sources; a register retiring this cycle is covered by regfile write-through.
  always_comb begin
    load_use  = 1'b0;
    mc_hazard = 1'b0;
    for (int p = 0; p < NUM_RS; p++) begin
      if (i_rs_used_D[p]) begin
        if (i_is_load_E && i_rd_addr_E != '0 && i_rs_addr_D[p] == i_rd_addr_E) begin
          load_use = 1'b1;
        end
        if (pending[i_rs_addr_D[p]] &&
            !(i_mc_wb_valid && i_mc_wb_addr == i_rs_addr_D[p])) begin
          mc_hazard = 1'b1;
        end
      end
    end
    if (pending[i_rd_addr_D] && !(i_mc_wb_valid && i_mc_wb_addr == i_rd_addr_D)) begin
      mc_hazard = 1'b1;
    end
    if (i_mc_req_D && mc_full) begin
      mc_hazard = 1'b1;
    end
  end

  assign o_stall_D = !i_reset && (load_use || mc_hazard || state == DRAIN);
  assign o_flush_E = !i_reset && (load_use || mc_hazard);
  assign o_mc_busy = (mc_count != '0);

  // Fence sequencing; fence_done is a registered pulse whenever a fence completes.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state        <= RUN;
      o_fence_done <= 1'b0;
    end else begin
      o_fence_done <= 1'b0;
      case (state)
        RUN: begin
          if (i_fence_D) begin
            if (mc_count != '0) begin
              state <= DRAIN;
            end else begin
              o_fence_done <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (mc_count == '0 || (mc_count == MC_CNT_W'(1) && i_mc_wb_valid)) begin
            state        <= RUN;
            o_fence_done <= 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  // Saturating stall-cycle counter; clear beats increment.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_stall_cycles <= '0;
    end else if (i_cnt_clr) begin
      o_stall_cycles <= '0;
    end else if (o_stall_D && o_stall_cycles != '1) begin
      o_stall_cycles <= o_stall_cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench: directed scenarios plus randomized traffic against a behavioural model.
module tb_fwd_hazard_unit;
  import hazard_pkg::*;

  localparam int NUM_RS   = 2;
  localparam int NUM_FWD  = 2;
  localparam int REG_AW   = 5;
  localparam int MC_DEPTH = 4;
  localparam int CNT_W    = 5;
  localparam int SELW     = $clog2(NUM_FWD + 1);
  localparam int NREGS    = 1 << REG_AW;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic                            i_clk = 1'b0;
  logic                            i_reset;
  logic [NUM_RS-1:0][REG_AW-1:0]   i_rs_addr_D;
  logic [NUM_RS-1:0]               i_rs_used_D;
  logic [REG_AW-1:0]               i_rd_addr_D;
  logic                            i_mc_req_D;
  logic                            i_fence_D;
  logic [REG_AW-1:0]               i_rd_addr_E;
  logic                            i_is_load_E;
  logic [NUM_FWD-1:0]              i_fwd_wren;
  logic [NUM_FWD-1:0][REG_AW-1:0]  i_fwd_addr;
  logic                            i_mc_issue;
  logic                            i_mc_wb_valid;
  logic [REG_AW-1:0]               i_mc_wb_addr;
  logic                            i_cnt_clr;
  logic [NUM_RS-1:0][SELW-1:0]     o_fwd_sel;
  logic                            o_stall_D;
  logic                            o_flush_E;
  logic                            o_mc_busy;
  logic                            o_fence_done;
  logic [CNT_W-1:0]                o_stall_cycles;

  int vectors     = 0;
  int miscompares = 0;

  // Behavioural model state (value after the most recent clock edge).
  bit m_pend[NREGS];
  int m_count     = 0;
  bit m_drain     = 1'b0;
  bit m_done      = 1'b0;
  int m_stall_cnt = 0;

  // Stimulus-side record of MC ops in flight, oldest first.
  int stim_q[$];

  fwd_hazard_unit #(
    .NUM_RS   (NUM_RS),
    .NUM_FWD  (NUM_FWD),
    .REG_AW   (REG_AW),
    .MC_DEPTH (MC_DEPTH),
    .CNT_W    (CNT_W)
  ) dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_rs_addr_D    (i_rs_addr_D),
    .i_rs_used_D    (i_rs_used_D),
    .i_rd_addr_D    (i_rd_addr_D),
    .i_mc_req_D     (i_mc_req_D),
    .i_fence_D      (i_fence_D),
    .i_rd_addr_E    (i_rd_addr_E),
    .i_is_load_E    (i_is_load_E),
    .i_fwd_wren     (i_fwd_wren),
    .i_fwd_addr     (i_fwd_addr),
    .i_mc_issue     (i_mc_issue),
    .i_mc_wb_valid  (i_mc_wb_valid),
    .i_mc_wb_addr   (i_mc_wb_addr),
    .i_cnt_clr      (i_cnt_clr),
    .o_fwd_sel      (o_fwd_sel),
    .o_stall_D      (o_stall_D),
    .o_flush_E      (o_flush_E),
    .o_mc_busy      (o_mc_busy),
    .o_fence_done   (o_fence_done),
    .o_stall_cycles (o_stall_cycles)
  );

  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    foreach (m_pend[r]) m_pend[r] = 1'b0;
    m_count     = 0;
    m_drain     = 1'b0;
    m_done      = 1'b0;
    m_stall_cnt = 0;
  endtask

  task automatic idleInputs();
    i_reset       = 1'b0;
    i_rs_addr_D   = '0;
    i_rs_used_D   = '0;
    i_rd_addr_D   = '0;
    i_mc_req_D    = 1'b0;
    i_fence_D     = 1'b0;
    i_rd_addr_E   = '0;
    i_is_load_E   = 1'b0;
    i_fwd_wren    = '0;
    i_fwd_addr    = '0;
    i_mc_issue    = 1'b0;
    i_mc_wb_valid = 1'b0;
    i_mc_wb_addr  = '0;
    i_cnt_clr     = 1'b0;
  endtask

  // Advance one clock, log accepted MC traffic, then return inputs to idle.
  task automatic nextCycle();
    @(posedge i_clk);
    if (i_reset) begin
      stim_q.delete();
    end else begin
      if (i_mc_issue) stim_q.push_back(int'(i_rd_addr_D));
      if (i_mc_wb_valid && stim_q.size() > 0) void'(stim_q.pop_front());
    end
    #1;
    idleInputs();
  endtask

  task automatic doReset();
    i_reset = 1'b1;
    #2;
    nextCycle();
  endtask

  // Random but protocol-legal traffic: issue only below capacity, retire oldest in flight.
  task automatic applyStimulus();
    i_reset = ($urandom_range(0, 399) == 0);
    for (int p = 0; p < NUM_RS; p++) i_rs_addr_D[p] = REG_AW'($urandom_range(0, 7));
    i_rs_used_D = NUM_RS'($urandom);
    i_rd_addr_D = REG_AW'($urandom_range(0, 7));
    i_mc_req_D  = ($urandom_range(0, 3) == 0);
    i_fence_D   = ($urandom_range(0, 15) == 0);
    i_rd_addr_E = REG_AW'($urandom_range(0, 7));
    i_is_load_E = ($urandom_range(0, 2) == 0);
    i_fwd_wren  = NUM_FWD'($urandom);
    for (int k = 0; k < NUM_FWD; k++) i_fwd_addr[k] = REG_AW'($urandom_range(0, 7));
    i_mc_issue = 1'b0;
    if (stim_q.size() < MC_DEPTH && $urandom_range(0, 3) == 0) begin
      i_mc_issue = 1'b1;
      i_mc_req_D = 1'b1;
    end
    i_mc_wb_valid = 1'b0;
    i_mc_wb_addr  = '0;
    if (stim_q.size() > 0 && $urandom_range(0, 3) == 0) begin
      i_mc_wb_valid = 1'b1;
      i_mc_wb_addr  = REG_AW'(stim_q[0]);
    end
    i_cnt_clr = ($urandom_range(0, 63) == 0);
  endtask

  // Compare every cycle against the model, then advance the model to the next edge.
  always @(negedge i_clk) begin
    bit       lu;
    bit       mh;
    bit       st;
    bit       nxt_drain;
    bit       nxt_done;
    int       r;
    fwd_sel_t exp_sel;
    if (i_reset) begin
      modelReset();
      for (int p = 0; p < NUM_RS; p++)
        checkOutput($sformatf("rst_fwd_sel%0d", p), 64'(o_fwd_sel[p]), 64'd0);
      checkOutput("rst_stall", 64'(o_stall_D), 64'd0);
      checkOutput("rst_flush", 64'(o_flush_E), 64'd0);
      checkOutput("rst_busy", 64'(o_mc_busy), 64'd0);
      checkOutput("rst_fence_done", 64'(o_fence_done), 64'd0);
      checkOutput("rst_stall_cycles", 64'(o_stall_cycles), 64'd0);
    end else begin
      for (int p = 0; p < NUM_RS; p++) begin
        exp_sel = '0;
        for (int k = 0; k < NUM_FWD; k++) begin
          if (i_fwd_wren[k] && i_fwd_addr[k] != 0 && i_fwd_addr[k] == i_rs_addr_D[p]) begin
            exp_sel = fwd_sel_t'(k + 1);
            break;
          end
        end
        checkOutput($sformatf("fwd_sel%0d", p), 64'(o_fwd_sel[p]), 64'(exp_sel));
      end
      lu = 1'b0;
      mh = 1'b0;
      for (int p = 0; p < NUM_RS; p++) begin
        if (i_rs_used_D[p]) begin
          r = int'(i_rs_addr_D[p]);
          if (i_is_load_E && i_rd_addr_E != 0 && r == int'(i_rd_addr_E)) lu = 1'b1;
          if (m_pend[r] && !(i_mc_wb_valid && int'(i_mc_wb_addr) == r)) mh = 1'b1;
        end
      end
      if (m_pend[i_rd_addr_D] && !(i_mc_wb_valid && i_mc_wb_addr == i_rd_addr_D)) mh = 1'b1;
      if (i_mc_req_D && m_count == MC_DEPTH) mh = 1'b1;
      st = lu || mh || m_drain;
      checkOutput("stall", 64'(o_stall_D), 64'(st));
      checkOutput("flush", 64'(o_flush_E), 64'(lu || mh));
      checkOutput("busy", 64'(o_mc_busy), 64'(m_count != 0));
      checkOutput("fence_done", 64'(o_fence_done), 64'(m_done));
      checkOutput("stall_cycles", 64'(o_stall_cycles), 64'(m_stall_cnt));

      nxt_drain = m_drain;
      nxt_done  = 1'b0;
      if (!m_drain) begin
        if (i_fence_D) begin
          if (m_count != 0) nxt_drain = 1'b1;
          else nxt_done = 1'b1;
        end
      end else if (m_count == 0 || (m_count == 1 && i_mc_wb_valid)) begin
        nxt_drain = 1'b0;
        nxt_done  = 1'b1;
      end
      m_drain = nxt_drain;
      m_done  = nxt_done;
      if (i_cnt_clr) m_stall_cnt = 0;
      else if (st && m_stall_cnt < CNT_MAX) m_stall_cnt++;
      if (i_mc_wb_valid) m_pend[i_mc_wb_addr] = 1'b0;
      if (i_mc_issue && i_rd_addr_D != 0) m_pend[i_rd_addr_D] = 1'b1;
      m_count = m_count + int'(i_mc_issue) - int'(i_mc_wb_valid);
    end
  end

  initial begin
    idleInputs();
    doReset();
    doReset();

    // Forwarding priority and register zero.
    $display("[TB] forwarding");
    i_fwd_wren = 2'b11; i_fwd_addr[0] = 5; i_fwd_addr[1] = 5; i_rs_addr_D[0] = 5;
    #2;
    checkOutput("t1_youngest_wins", 64'(o_fwd_sel[0]), 64'd1);
    checkOutput("t1_port1_none", 64'(o_fwd_sel[1]), 64'd0);
    nextCycle();
    i_fwd_wren = 2'b11;
    #2;
    checkOutput("t1_x0_never_fwd", 64'(o_fwd_sel[0]), 64'd0);
    nextCycle();
    i_fwd_wren = 2'b11; i_fwd_addr[0] = 3; i_fwd_addr[1] = 5;
    i_rs_addr_D[0] = 5; i_rs_addr_D[1] = 3;
    #2;
    checkOutput("t1_oldest_stage", 64'(o_fwd_sel[0]), 64'd2);
    checkOutput("t1_young_stage", 64'(o_fwd_sel[1]), 64'd1);
    nextCycle();

    // Load-use.
    $display("[TB] load-use");
    i_is_load_E = 1; i_rd_addr_E = 7; i_rs_addr_D[1] = 7; i_rs_used_D = 2'b10;
    #2;
    checkOutput("t2_lu_stall", 64'(o_stall_D), 64'd1);
    checkOutput("t2_lu_flush", 64'(o_flush_E), 64'd1);
    nextCycle();
    i_is_load_E = 1; i_rd_addr_E = 7; i_rs_addr_D[1] = 7; i_rs_used_D = 2'b00;
    #2;
    checkOutput("t2_unused_no_stall", 64'(o_stall_D), 64'd0);
    nextCycle();
    #2;
    checkOutput("t2_one_stall_counted", 64'(o_stall_cycles), 64'd1);
    nextCycle();

    // MC RAW stall released by write-through.
    $display("[TB] multi-cycle RAW");
    i_mc_req_D = 1; i_rd_addr_D = 9; i_mc_issue = 1;
    #2;
    checkOutput("t3_issue_no_stall", 64'(o_stall_D), 64'd0);
    nextCycle();
    for (int c = 0; c < 2; c++) begin
      i_rs_used_D = 2'b01; i_rs_addr_D[0] = 9;
      #2;
      checkOutput("t3_raw_stall", 64'(o_stall_D), 64'd1);
      checkOutput("t3_busy", 64'(o_mc_busy), 64'd1);
      nextCycle();
    end
    i_rs_used_D = 2'b01; i_rs_addr_D[0] = 9; i_mc_wb_valid = 1; i_mc_wb_addr = 9;
    #2;
    checkOutput("t3_wb_cycle_no_stall", 64'(o_stall_D), 64'd0);
    nextCycle();
    i_rs_used_D = 2'b01; i_rs_addr_D[0] = 9;
    #2;
    checkOutput("t3_cleared_no_stall", 64'(o_stall_D), 64'd0);
    checkOutput("t3_idle", 64'(o_mc_busy), 64'd0);
    nextCycle();

    // Capacity.
    $display("[TB] capacity");
    doReset();
    for (int i = 1; i <= MC_DEPTH; i++) begin
      i_mc_req_D = 1; i_rd_addr_D = REG_AW'(i); i_mc_issue = 1;
      #2;
      checkOutput("t4_fill_no_stall", 64'(o_stall_D), 64'd0);
      nextCycle();
    end
    i_mc_req_D = 1; i_rd_addr_D = 10;
    #2;
    checkOutput("t4_full_stall", 64'(o_stall_D), 64'd1);
    nextCycle();
    i_mc_req_D = 1; i_rd_addr_D = 10; i_mc_issue = 1; i_mc_wb_valid = 1; i_mc_wb_addr = 1;
    #2;
    nextCycle();
    i_mc_req_D = 1; i_rd_addr_D = 11;
    #2;
    checkOutput("t4_still_full", 64'(o_stall_D), 64'd1);
    nextCycle();
    i_rs_used_D = 2'b01; i_rs_addr_D[0] = 1;
    #2;
    checkOutput("t4_retired_reg_free", 64'(o_stall_D), 64'd0);
    nextCycle();
    i_rs_used_D = 2'b10; i_rs_addr_D[1] = 10;
    #2;
    checkOutput("t4_new_reg_pending", 64'(o_stall_D), 64'd1);
    nextCycle();

    // Fence drain.
    $display("[TB] fence");
    doReset();
    i_mc_req_D = 1; i_rd_addr_D = 12; i_mc_issue = 1; i_cnt_clr = 1;
    nextCycle();
    i_mc_req_D = 1; i_rd_addr_D = 13; i_mc_issue = 1;
    nextCycle();
    i_fence_D = 1;
    #2;
    checkOutput("t5_fence_cycle", 64'(o_stall_D), 64'd0);
    nextCycle();
    #2;
    checkOutput("t5_drain_stall", 64'(o_stall_D), 64'd1);
    checkOutput("t5_drain_no_flush", 64'(o_flush_E), 64'd0);
    nextCycle();
    i_mc_wb_valid = 1; i_mc_wb_addr = 12;
    #2;
    checkOutput("t5_first_wb_stall", 64'(o_stall_D), 64'd1);
    nextCycle();
    i_mc_wb_valid = 1; i_mc_wb_addr = 13;
    #2;
    checkOutput("t5_last_wb_stall", 64'(o_stall_D), 64'd1);
    checkOutput("t5_done_not_yet", 64'(o_fence_done), 64'd0);
    nextCycle();
    #2;
    checkOutput("t5_released", 64'(o_stall_D), 64'd0);
    checkOutput("t5_done_pulse", 64'(o_fence_done), 64'd1);
    checkOutput("t5_drain_cycles", 64'(o_stall_cycles), 64'd3);
    nextCycle();
    i_fence_D = 1;
    #2;
    checkOutput("t5_done_single", 64'(o_fence_done), 64'd0);
    checkOutput("t5_empty_fence_no_stall", 64'(o_stall_D), 64'd0);
    nextCycle();
    #2;
    checkOutput("t5_empty_fence_done", 64'(o_fence_done), 64'd1);
    nextCycle();

    // Reset in the middle of a drain.
    $display("[TB] reset mid-drain");
    doReset();
    i_mc_req_D = 1; i_rd_addr_D = 14; i_mc_issue = 1;
    nextCycle();
    i_mc_req_D = 1; i_rd_addr_D = 15; i_mc_issue = 1;
    nextCycle();
    i_fence_D = 1;
    nextCycle();
    i_fwd_wren = 2'b01; i_fwd_addr[0] = 6; i_rs_addr_D[0] = 6;
    #2;
    checkOutput("t6_in_drain", 64'(o_stall_D), 64'd1);
    nextCycle();
    i_fwd_wren = 2'b01; i_fwd_addr[0] = 15; i_rs_addr_D[0] = 15; i_rs_used_D = 2'b01;
    i_reset = 1;
    #1;
    checkOutput("t6_rst_stall", 64'(o_stall_D), 64'd0);
    checkOutput("t6_rst_flush", 64'(o_flush_E), 64'd0);
    checkOutput("t6_rst_fwd", 64'(o_fwd_sel[0]), 64'd0);
    checkOutput("t6_rst_busy", 64'(o_mc_busy), 64'd0);
    checkOutput("t6_rst_cnt", 64'(o_stall_cycles), 64'd0);
    nextCycle();
    i_rs_used_D = 2'b01; i_rs_addr_D[0] = 15;
    #2;
    checkOutput("t6_pending_gone", 64'(o_stall_D), 64'd0);
    checkOutput("t6_no_done", 64'(o_fence_done), 64'd0);
    nextCycle();
    #2;
    checkOutput("t6_still_no_done", 64'(o_fence_done), 64'd0);
    nextCycle();

    // Counter saturation and clear priority.
    $display("[TB] counter saturation");
    doReset();
    repeat (CNT_MAX + 3) begin
      i_is_load_E = 1; i_rd_addr_E = 3; i_rs_addr_D[0] = 3; i_rs_used_D = 2'b01;
      nextCycle();
    end
    i_is_load_E = 1; i_rd_addr_E = 3; i_rs_addr_D[0] = 3; i_rs_used_D = 2'b01;
    #2;
    checkOutput("t7_saturated", 64'(o_stall_cycles), 64'(CNT_MAX));
    nextCycle();
    i_is_load_E = 1; i_rd_addr_E = 3; i_rs_addr_D[0] = 3; i_rs_used_D = 2'b01; i_cnt_clr = 1;
    #2;
    checkOutput("t7_no_wrap", 64'(o_stall_cycles), 64'(CNT_MAX));
    nextCycle();
    i_is_load_E = 1; i_rd_addr_E = 3; i_rs_addr_D[0] = 3; i_rs_used_D = 2'b01;
    #2;
    checkOutput("t7_clear_wins", 64'(o_stall_cycles), 64'd0);
    nextCycle();
    #2;
    checkOutput("t7_counts_again", 64'(o_stall_cycles), 64'd1);
    nextCycle();

    // Randomized traffic, checked every cycle by the model.
    $display("[TB] random traffic");
    doReset();
    repeat (3000) begin
      applyStimulus();
      #2;
      nextCycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
